// File: rtl/scan_driver_pkg.sv
// Shared declarations for the external scan-chain driver: FSM states, slot phases, stream length.
package scan_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_LATCH,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_DONE
  } state_e;

  // Every bit slot is a low phase followed by a high phase of scan_clk.
  localparam logic PH_LOW  = 1'b0;
  localparam logic PH_HIGH = 1'b1;

  function automatic int stream_len(input int num_designs, input int io_width);
    return num_designs * io_width;
  endfunction

endpackage

// File: rtl/scan_driver_clk_gen.sv
// Divider for the scan clock: each phase lasts div+1 clk cycles; emits sample and slot-end strobes.
module scan_clk_gen
  import scan_driver_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             phase_hi,
  output logic             sample,
  output logic             slot_end
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             tick;

  assign tick = (cnt_q == div);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run) begin
      cnt_d   = '0;
      phase_d = PH_LOW;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= PH_LOW;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_hi = phase_q;
  assign sample   = run && tick && (phase_q == PH_LOW);
  assign slot_end = run && tick && (phase_q == PH_HIGH);

endmodule

// File: rtl/scan_chain_driver.sv
// External scan-chain master: shifts one design's input word in, latches, captures, shifts the result out.
// Optional macro SCAN_DRIVER_SLOW_CLK_EN: a toggle flop (flipped at each ready) drives slow_clk and replaces inputs[0].
module scan_chain_driver
  import scan_driver_pkg::*;
#(
  parameter int NUM_DESIGNS = 4,
  parameter int IO_WIDTH    = 8,
  parameter int DIV_W       = 4,
  parameter int SEL_W       = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SEL_W-1:0]    active_select,
  input  logic [IO_WIDTH-1:0] inputs,
  input  logic                set_clk_div,
  input  logic [DIV_W-1:0]    clk_div_in,
  output logic                busy,
  output logic [IO_WIDTH-1:0] outputs,
  output logic                ready,
  output logic                sel_err,
  output logic                scan_clk,
  output logic                scan_data_out,
  output logic                scan_select,
  output logic                scan_latch,
  input  logic                scan_data_in,
  output logic                slow_clk
);

  localparam int T     = stream_len(NUM_DESIGNS, IO_WIDTH);
  localparam int CNT_W = (T > 1) ? $clog2(T) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(T - 1);

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [T-1:0]        stream_q, stream_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    win_lo_q, win_lo_d;
  logic                tgt_ok_q, tgt_ok_d;
  logic [IO_WIDTH-1:0] shadow_q, shadow_d;
  logic [IO_WIDTH-1:0] outputs_q, outputs_d;
  logic                ready_q, ready_d;
  logic                sel_err_q, sel_err_d;
  logic [IO_WIDTH-1:0] word_in;
  logic                sel_ok, in_window;
  logic                run, phase_hi, sample, slot_end;

  assign run = (state_q == ST_SHIFT_IN) || (state_q == ST_LATCH) ||
               (state_q == ST_CAPTURE)  || (state_q == ST_SHIFT_OUT);

  scan_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .div      (div_q),
    .phase_hi (phase_hi),
    .sample   (sample),
    .slot_end (slot_end)
  );

`ifdef SCAN_DRIVER_SLOW_CLK_EN
  logic toggle_q, toggle_d;

  always_comb begin
    toggle_d   = ready_d ? ~toggle_q : toggle_q;
    word_in    = inputs;
    word_in[0] = toggle_q;
  end

  always_ff @(posedge clk) begin
    if (reset) toggle_q <= 1'b0;
    else       toggle_q <= toggle_d;
  end

  assign slow_clk = toggle_q;
`else
  assign word_in  = inputs;
  assign slow_clk = 1'b0;
`endif

  assign sel_ok = (int'(active_select) < NUM_DESIGNS);

  // Slot indices of the target word in the returning stream (design NUM_DESIGNS-1 arrives first).
  assign in_window = (int'(bit_cnt_q) >= int'(win_lo_q)) &&
                     (int'(bit_cnt_q) <  int'(win_lo_q) + IO_WIDTH);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    stream_d  = stream_q;
    bit_cnt_d = bit_cnt_q;
    win_lo_d  = win_lo_q;
    tgt_ok_d  = tgt_ok_q;
    shadow_d  = shadow_q;
    outputs_d = outputs_q;
    ready_d   = 1'b0;
    sel_err_d = sel_err_q;
    case (state_q)
      ST_IDLE: begin
        if (set_clk_div) div_d = clk_div_in;
        if (start) begin
          state_d   = ST_SHIFT_IN;
          bit_cnt_d = '0;
          shadow_d  = '0;
          tgt_ok_d  = sel_ok;
          stream_d  = '0;
          win_lo_d  = '0;
          if (sel_ok) begin
            stream_d = T'(word_in) << (int'(active_select) * IO_WIDTH);
            win_lo_d = CNT_W'((NUM_DESIGNS - 1 - int'(active_select)) * IO_WIDTH);
          end
        end
      end
      ST_SHIFT_IN: begin
        if (slot_end) begin
          stream_d = {stream_q[T-2:0], 1'b0};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LATCH: begin
        if (slot_end) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (slot_end) state_d = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        if (sample && tgt_ok_q && in_window) shadow_d = {shadow_q[IO_WIDTH-2:0], scan_data_in};
        if (slot_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_DONE;
            ready_d   = 1'b1;
            outputs_d = shadow_q;
            sel_err_d = ~tgt_ok_q;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tgt_ok_q  <= 1'b0;
      outputs_q <= '0;
      ready_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tgt_ok_q  <= tgt_ok_d;
      outputs_q <= outputs_d;
      ready_q   <= ready_d;
      sel_err_q <= sel_err_d;
    end
  end

  // NOTE: datapath registers carry no reset; every accepted start rewrites them before they are observed.
  always_ff @(posedge clk) begin
    stream_q <= stream_d;
    win_lo_q <= win_lo_d;
    shadow_q <= shadow_d;
  end

  assign busy          = run;
  assign outputs       = outputs_q;
  assign ready         = ready_q;
  assign sel_err       = sel_err_q;
  assign scan_clk      = phase_hi && ((state_q == ST_SHIFT_IN) || (state_q == ST_CAPTURE) ||
                                      (state_q == ST_SHIFT_OUT));
  assign scan_data_out = (state_q == ST_SHIFT_IN) && stream_q[T-1];
  assign scan_select   = (state_q == ST_CAPTURE);
  assign scan_latch    = (state_q == ST_LATCH);

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: behavioural chain of loop-back designs plus a transaction-level reference.
module tb_scan_chain_driver;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DW = 4;
  localparam int SW = 3;
  localparam int T  = N * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, set_clk_div = 1'b0;
  logic [SW-1:0] active_select = '0;
  logic [W-1:0]  inputs = '0;
  logic [DW-1:0] clk_div_in = '0;
  logic          scan_data_in;
  logic          busy, ready, sel_err, scan_clk, scan_data_out, scan_select, scan_latch, slow_clk;
  logic [W-1:0]  outputs;

  int   vectors = 0;
  int   miscompares = 0;
  int   cur_div = 0;
  logic tgl_model = 1'b0;

  // chain[0] is the flop feeding scan_data_in; chain[k] holds the k-th bit of a shifted-in stream.
  logic [T-1:0] chain = '0;
  logic [T-1:0] cap;
  logic [W-1:0] design_in [N] = '{default: '0};

  always #5 clk = ~clk;

  scan_chain_driver #(.NUM_DESIGNS(N), .IO_WIDTH(W), .DIV_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .active_select(active_select), .inputs(inputs),
    .set_clk_div(set_clk_div), .clk_div_in(clk_div_in), .busy(busy), .outputs(outputs),
    .ready(ready), .sel_err(sel_err), .scan_clk(scan_clk), .scan_data_out(scan_data_out),
    .scan_select(scan_select), .scan_latch(scan_latch), .scan_data_in(scan_data_in),
    .slow_clk(slow_clk)
  );

  function automatic int chain_idx(input int d, input int b);
    return (N - 1 - d) * W + (W - 1 - b);
  endfunction

  assign scan_data_in = chain[0];

  // Each design simply returns its latched input word as its output word.
  always @(posedge scan_clk) begin
    if (scan_select) begin
      cap = '0;
      for (int d = 0; d < N; d++)
        for (int b = 0; b < W; b++) cap[chain_idx(d, b)] = design_in[d][b];
      chain <= cap;
    end else begin
      chain <= {scan_data_out, chain[T-1:1]};
    end
  end

  always @(negedge clk) begin
    if (scan_latch)
      for (int d = 0; d < N; d++)
        for (int b = 0; b < W; b++) design_in[d][b] = chain[chain_idx(d, b)];
  end

  function automatic logic [W-1:0] eff_word(input logic [W-1:0] word);
`ifdef SCAN_DRIVER_SLOW_CLK_EN
    return {word[W-1:1], tgl_model};
`else
    return word;
`endif
  endfunction

  function automatic logic exp_slow();
`ifdef SCAN_DRIVER_SLOW_CLK_EN
    return tgl_model;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_lat();
    return 2 * (cur_div + 1) * (2 * T + 2) + 1;
  endfunction

  task automatic set_div(input int d);
    @(negedge clk);
    set_clk_div = 1'b1;
    clk_div_in  = DW'(d);
    @(negedge clk);
    set_clk_div = 1'b0;
    cur_div     = d;
  endtask

  // Runs one transaction and reports what was observed; the calling test judges it.
  task automatic do_txn(input logic [SW-1:0] sel, input logic [W-1:0] word, input int new_div,
                        input bit disturb, output int lat, output int readies, output logic busy1,
                        output logic busy_r, output logic [W-1:0] outs, output logic serr,
                        output int rise1, output int rise2);
    int   cyc = 0;
    int   limit;
    logic prev_sclk = 1'b0;
    @(negedge clk);
    active_select = sel;
    inputs        = word;
    start         = 1'b1;
    if (new_div >= 0) begin
      set_clk_div = 1'b1;
      clk_div_in  = DW'(new_div);
      cur_div     = new_div;
    end
    limit = exp_lat() + 40;
    lat = -1; readies = 0; busy1 = 1'b0; busy_r = 1'b1; outs = '0; serr = 1'b0;
    rise1 = -1; rise2 = -1;
    while (cyc < limit && !(lat >= 0 && cyc >= lat + 20)) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; set_clk_div = 1'b0; busy1 = busy;
      end
      if (disturb && cyc == 10) begin
        start = 1'b1; set_clk_div = 1'b1; clk_div_in = DW'(cur_div + 2);
        active_select = ~sel; inputs = ~word;
      end
      if (disturb && cyc == 11) begin
        start = 1'b0; set_clk_div = 1'b0;
      end
      if (scan_clk && !prev_sclk) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      prev_sclk = scan_clk;
      if (ready) begin
        readies++;
        if (lat < 0) begin
          lat = cyc; outs = outputs; serr = sel_err; busy_r = busy;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, ready, sel_err, outputs, scan_clk, scan_data_out, scan_select, scan_latch, slow_clk} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required all zero",
               {busy, ready, sel_err, outputs, scan_clk, scan_data_out, scan_select, scan_latch, slow_clk});
    end
    @(negedge clk);
    reset = 1'b0; cur_div = 0; tgl_model = 1'b0;
  endtask

  task automatic test_basic();
    int lat, rd, r1, r2; logic b1, br, se; logic [W-1:0] o, ew;
    ew = eff_word(8'hA5);
    do_txn(3'd2, 8'hA5, -1, 1'b0, lat, rd, b1, br, o, se, r1, r2);
    tgl_model = ~tgl_model;
    vectors++;
    if (lat !== 133) begin miscompares++; $display("FAIL basic_latency: got %0d required 133", lat); end
    vectors++;
    if (o !== ew) begin miscompares++; $display("FAIL basic_outputs: got %h required %h", o, ew); end
    vectors++;
    if (se !== 1'b0) begin miscompares++; $display("FAIL basic_sel_err: got %b required 0", se); end
    vectors++;
    if ({b1, br} !== 2'b10) begin miscompares++; $display("FAIL basic_busy: got %b required 10", {b1, br}); end
    vectors++;
    if (design_in[2] !== ew) begin miscompares++; $display("FAIL basic_latched: got %h required %h", design_in[2], ew); end
  endtask

  task automatic test_divider();
    int lat, rd, r1, r2; logic b1, br, se; logic [W-1:0] o, w, ew;
    set_div(3);
    w  = W'($urandom);
    ew = eff_word(w);
    do_txn(3'd1, w, -1, 1'b0, lat, rd, b1, br, o, se, r1, r2);
    tgl_model = ~tgl_model;
    vectors++;
    if (lat !== 529) begin miscompares++; $display("FAIL div_latency: got %0d required 529", lat); end
    vectors++;
    if (r1 !== 5) begin miscompares++; $display("FAIL div_first_rise: got %0d required 5", r1); end
    vectors++;
    if (r2 - r1 !== 8) begin miscompares++; $display("FAIL div_period: got %0d required 8", r2 - r1); end
    vectors++;
    if (o !== ew) begin miscompares++; $display("FAIL div_outputs: got %h required %h", o, ew); end
  endtask

  task automatic test_load_with_start();
    int lat, rd, r1, r2; logic b1, br, se; logic [W-1:0] o, w, ew;
    w  = W'($urandom);
    ew = eff_word(w);
    do_txn(3'd3, w, 1, 1'b0, lat, rd, b1, br, o, se, r1, r2);
    tgl_model = ~tgl_model;
    vectors++;
    if (lat !== 265) begin miscompares++; $display("FAIL load_start_latency: got %0d required 265", lat); end
    vectors++;
    if (r2 - r1 !== 4) begin miscompares++; $display("FAIL load_start_period: got %0d required 4", r2 - r1); end
    vectors++;
    if (o !== ew) begin miscompares++; $display("FAIL load_start_outputs: got %h required %h", o, ew); end
  endtask

  task automatic test_sel_err();
    int lat, rd, r1, r2; logic b1, br, se; logic [W-1:0] o;
    do_txn(3'd5, 8'hFF, 0, 1'b0, lat, rd, b1, br, o, se, r1, r2);
    tgl_model = ~tgl_model;
    vectors++;
    if (lat !== 133) begin miscompares++; $display("FAIL selerr_latency: got %0d required 133", lat); end
    vectors++;
    if ({se, o} !== {1'b1, 8'h00}) begin
      miscompares++; $display("FAIL selerr_result: got sel_err=%b outputs=%h required 1/00", se, o);
    end
    for (int d = 0; d < N; d++) begin
      vectors++;
      if (design_in[d] !== '0) begin
        miscompares++; $display("FAIL selerr_stream d%0d: got %h required 00", d, design_in[d]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, rd, r1, r2, el; logic b1, br, se; logic [W-1:0] o, w, ew;
    w  = W'($urandom);
    ew = eff_word(w);
    el = exp_lat();
    do_txn(3'd0, w, -1, 1'b1, lat, rd, b1, br, o, se, r1, r2);
    tgl_model = ~tgl_model;
    vectors++;
    if (lat !== el) begin miscompares++; $display("FAIL busy_latency: got %0d required %0d", lat, el); end
    vectors++;
    if (rd !== 1) begin miscompares++; $display("FAIL busy_ready_count: got %0d required 1", rd); end
    vectors++;
    if (o !== ew) begin miscompares++; $display("FAIL busy_outputs: got %h required %h", o, ew); end
  endtask

  task automatic test_reset_abort();
    int lat, rd, r1, r2; logic b1, br, se; logic [W-1:0] o, w, ew;
    w = W'($urandom);
    @(negedge clk);
    active_select = 3'd3; inputs = w; start = 1'b1; set_clk_div = 1'b1; clk_div_in = '0; cur_div = 0;
    @(posedge clk); #1;
    start = 1'b0; set_clk_div = 1'b0;
    repeat (79) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before: got %b required 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, ready, outputs, scan_clk, scan_data_out, scan_select, scan_latch} !== '0) begin
      miscompares++;
      $display("FAIL abort_pins: got %b required all zero",
               {busy, ready, outputs, scan_clk, scan_data_out, scan_select, scan_latch});
    end
    reset = 1'b0; tgl_model = 1'b0; cur_div = 0;
    ew = eff_word(w);
    do_txn(3'd3, w, -1, 1'b0, lat, rd, b1, br, o, se, r1, r2);
    tgl_model = ~tgl_model;
    vectors++;
    if (lat !== 133) begin miscompares++; $display("FAIL abort_restart_latency: got %0d required 133", lat); end
    vectors++;
    if (o !== ew) begin miscompares++; $display("FAIL abort_restart_outputs: got %h required %h", o, ew); end
  endtask

  task automatic test_random();
    int lat, rd, r1, r2, el, nd; logic b1, br, se; logic [W-1:0] o, w, ew, exp_o, exp_d;
    logic [SW-1:0] sel; logic sel_valid;
    for (int i = 0; i < 6; i++) begin
      sel       = SW'($urandom_range(0, 7));
      w         = W'($urandom);
      nd        = int'($urandom_range(0, 2));
      sel_valid = int'(sel) < N;
      if ($urandom_range(0, 1) == 1) begin
        set_div(nd);
        nd = -1;
      end else begin
        cur_div = nd;
      end
      ew    = eff_word(w);
      exp_o = sel_valid ? ew : '0;
      el    = exp_lat();
      do_txn(sel, w, nd, 1'b0, lat, rd, b1, br, o, se, r1, r2);
      tgl_model = ~tgl_model;
      vectors++;
      if (lat !== el) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d required %0d", i, lat, el); end
      vectors++;
      if ({se, o} !== {~sel_valid, exp_o}) begin
        miscompares++;
        $display("FAIL rnd%0d_result: got sel_err=%b outputs=%h required %b/%h", i, se, o, ~sel_valid, exp_o);
      end
      vectors++;
      if (slow_clk !== exp_slow()) begin
        miscompares++; $display("FAIL rnd%0d_slow_clk: got %b required %b", i, slow_clk, exp_slow());
      end
      for (int d = 0; d < N; d++) begin
        exp_d = (sel_valid && d == int'(sel)) ? ew : '0;
        vectors++;
        if (design_in[d] !== exp_d) begin
          miscompares++; $display("FAIL rnd%0d_stream d%0d: got %h required %h", i, d, design_in[d], exp_d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_load_with_start();
    test_sel_err();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
